// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: FWFT FIFO with error flags,
// RTS hysteresis, trigger-level and character-timeout interrupts, sticky overrun.
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int RTS_HI        = 12,
    parameter int RTS_LO        = 8,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick_i,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       wr_parity_err_i,
    input  logic                       wr_stop_err_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 rd_data_o,
    output logic                       rd_parity_err_o,
    output logic                       rd_stop_err_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    input  logic [1:0]                 trig_level_i,
    output logic                       level_irq_o,
    output logic                       timeout_o,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i,
    output logic                       rts_no
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovr_q, ovr_d;
    logic          rts_q, rts_d;
    logic          irq_q, irq_d;
    logic          empty, full, push, pop;
    logic [CW-1:0] lvl;
    logic [9:0]    head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign push = wr_valid_i & (~full | rd_en_i) & ~flush_i;
    assign pop  = rd_en_i & ~empty & ~flush_i;

    always_comb begin
        lvl = CW'(1);
        unique case (trig_level_i)
            2'b00: lvl = CW'(1);
            2'b01: lvl = CW'(4);
            2'b10: lvl = CW'(8);
            2'b11: lvl = CW'(DEPTH - 2);
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (wr_valid_i & full & ~rd_en_i) begin
            ovr_d = 1'b1;
        end else if (overrun_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        rts_d = rts_q;
        if (count_d >= CW'(RTS_HI)) begin
            rts_d = 1'b1;
        end else if (count_d <= CW'(RTS_LO)) begin
            rts_d = 1'b0;
        end
        irq_d = (count_d >= lvl);
    end

    always_comb begin
        tmo_d = tmo_q;
        if (flush_i | push | pop | empty) begin
            tmo_d = '0;
        end else if (tick_i && tmo_q != TW'(TIMEOUT_TICKS)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmo_q    <= '0;
            ovr_q    <= 1'b0;
            rts_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
            rts_q    <= rts_d;
            irq_q    <= irq_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_stop_err_i, wr_parity_err_i, wr_data_i};
        end
    end

    assign head            = empty ? 10'd0 : mem_q[rd_ptr_q];
    assign rd_data_o       = head[7:0];
    assign rd_parity_err_o = head[8];
    assign rd_stop_err_o   = head[9];
    assign count_o         = count_q;
    assign empty_o         = empty;
    assign full_o          = full;
    assign level_irq_o     = irq_q;
    assign timeout_o       = (tmo_q == TW'(TIMEOUT_TICKS)) & ~empty;
    assign overrun_o       = ovr_q;
    assign rts_no          = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_i, flush_i, wr_valid_i;
    logic [7:0] wr_data_i;
    logic       wr_parity_err_i, wr_stop_err_i, rd_en_i;
    logic [7:0] rd_data_o;
    logic       rd_parity_err_o, rd_stop_err_o;
    logic [4:0] count_o;
    logic       empty_o, full_o;
    logic [1:0] trig_level_i;
    logic       level_irq_o, timeout_o, overrun_o, overrun_clr_i, rts_no;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .tick_i(tick_i), .flush_i(flush_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
        .wr_parity_err_i(wr_parity_err_i), .wr_stop_err_i(wr_stop_err_i),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
        .rd_parity_err_o(rd_parity_err_o), .rd_stop_err_o(rd_stop_err_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .trig_level_i(trig_level_i), .level_irq_o(level_irq_o),
        .timeout_o(timeout_o), .overrun_o(overrun_o),
        .overrun_clr_i(overrun_clr_i), .rts_no(rts_no)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int mq[$];
    int exp_q[$];
    bit m_ov, m_rts, m_irq;
    int m_tmo;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lvl_of(input logic [1:0] t);
        case (t)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 14;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ov = 0; m_rts = 0; m_irq = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit fl, wv, input int ent,
                              input bit rd, ocl, tk);
        int  sz  = mq.size();
        bit  ful = (sz == 16);
        bit  emp = (sz == 0);
        bit  popok, pushok;
        int  n;
        if (wv && ful && !rd) m_ov = 1;
        else if (ocl) m_ov = 0;
        if (fl) begin
            mq.delete();
            m_tmo = 0;
        end else begin
            popok  = rd && !emp;
            pushok = wv && (!ful || rd);
            if (popok) begin
                exp_q.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (pushok) mq.push_back(ent);
            if (pushok || popok || emp) m_tmo = 0;
            else if (tk && m_tmo < 64) m_tmo++;
        end
        n = mq.size();
        if (n >= 12) m_rts = 1;
        else if (n <= 8) m_rts = 0;
        m_irq = (n >= lvl_of(trig_level_i));
    endtask

    task automatic check_state();
        int sz = mq.size();
        chk("count", int'(count_o), sz);
        chk("empty", int'(empty_o), int'(sz == 0));
        chk("full", int'(full_o), int'(sz == 16));
        chk("overrun", int'(overrun_o), int'(m_ov));
        chk("rts", int'(rts_no), int'(m_rts));
        chk("level_irq", int'(level_irq_o), int'(m_irq));
        chk("timeout", int'(timeout_o), int'(m_tmo == 64 && sz > 0));
        chk("head", int'({rd_stop_err_o, rd_parity_err_o, rd_data_o}),
            (sz == 0) ? 0 : mq[0]);
    endtask

    task automatic cycle(input bit fl, wv, input logic [7:0] d,
                         input bit pe, se, rd, ocl, tk);
        flush_i = fl; wr_valid_i = wv; wr_data_i = d;
        wr_parity_err_i = pe; wr_stop_err_i = se;
        rd_en_i = rd; overrun_clr_i = ocl; tick_i = tk;
        model_step(fl, wv, int'({se, pe, d}), rd, ocl, tk);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic push(input logic [7:0] d);
        cycle(0, 1, d, 0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        cycle(0, 0, 8'h00, 0, 0, 1, 0, 0);
    endtask

    task automatic idle(input int n, input bit tk);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0, 0, 0, tk);
    endtask

    // Monitor: every accepted pop must present the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && !flush_i && rd_en_i && !empty_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected none at %0t",
                         {rd_stop_err_o, rd_parity_err_o, rd_data_o}, $time);
            end else begin
                chk("pop_data", int'({rd_stop_err_o, rd_parity_err_o, rd_data_o}),
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; tick_i = 0; flush_i = 0; wr_valid_i = 0; wr_data_i = 0;
        wr_parity_err_i = 0; wr_stop_err_i = 0; rd_en_i = 0;
        overrun_clr_i = 0; trig_level_i = 2'b00;
        model_reset();
        #12;
        check_state();
        reset = 0;
        @(posedge clk);
        #1;

        // Basic FWFT ordering
        push(8'h41);
        push(8'h42);
        chk("basic_count", int'(count_o), 2);
        chk("basic_head", int'(rd_data_o), 8'h41);
        pop();
        chk("basic_head2", int'(rd_data_o), 8'h42);
        pop();
        chk("basic_empty_data", int'(rd_data_o), 0);

        // Fill, overrun, clear, full push+pop, drain
        trig_level_i = 2'b01;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        cycle(0, 1, 8'hEE, 0, 0, 0, 0, 0);
        chk("ovr_set", int'(overrun_o), 1);
        chk("ovr_count", int'(count_o), 16);
        cycle(0, 0, 8'h00, 0, 0, 0, 1, 0);
        chk("ovr_clr", int'(overrun_o), 0);
        cycle(0, 1, 8'hA5, 1, 1, 1, 0, 0);
        chk("full_rw_count", int'(count_o), 16);
        for (int i = 0; i < 16; i++) pop();

        // Parity-flagged byte then character timeout
        trig_level_i = 2'b00;
        cycle(0, 1, 8'h5A, 1, 0, 0, 0, 0);
        idle(64, 1);
        chk("tmo_set", int'(timeout_o), 1);
        chk("tmo_par", int'(rd_parity_err_o), 1);
        pop();
        chk("tmo_clr", int'(timeout_o), 0);

        // Flush beats a simultaneous write
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        cycle(1, 1, 8'h77, 0, 0, 0, 0, 0);
        chk("flush_count", int'(count_o), 0);

        // Asynchronous reset mid-push
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        wr_valid_i = 1; wr_data_i = 8'h99;
        #2;
        reset = 1;
        #1;
        model_reset();
        check_state();
        wr_valid_i = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // Randomized phases with varying push/pop bias
        for (int ph = 0; ph < 30; ph++) begin
            int pw = $urandom_range(20, 90);
            int pr = $urandom_range(10, 80);
            trig_level_i = 2'($urandom_range(0, 3));
            for (int c = 0; c < 100; c++) begin
                cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 99) < pw),
                      8'($urandom),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 99) < pr),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 2) == 0));
            end
            if (ph % 10 == 9) idle(70, 1);
        end

        idle(1, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
